// File: rtl/cbfp_denorm_pkg.sv
// Purpose : shared widths and the exponent-pair type for the CBFP denormaliser.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: DATA_WIDTH, OUT_WIDTH, BLOCK_SIZE, LZC_WIDTH, exp_pair_t.
package cbfp_denorm_pkg;

  localparam int DATA_WIDTH = 12;  // normalised lane width
  localparam int OUT_WIDTH  = 16;  // denormalised lane width
  localparam int BLOCK_SIZE = 8;   // lanes per block
  localparam int LZC_WIDTH  = 5;   // block exponent width

  // One FIFO entry: the add-path and sub-path exponents of a single block.
  typedef struct packed {
    logic [LZC_WIDTH-1:0] exp_add;
    logic [LZC_WIDTH-1:0] exp_sub;
  } exp_pair_t;

endpackage

// File: rtl/cbfp_denorm_exp_fifo.sv
// Purpose : in-order synchronous FIFO with occupancy level, full and empty flags.
// Latency : show-ahead; o_rdata is the oldest entry combinationally, a push is visible the next cycle.
// Backpr. : none; a push while full is ignored unless a pop happens in the same cycle, a pop while empty is ignored.
// Ports   : i_clk/i_rstn clock and async active-low reset; i_push/i_wdata write side;
//           i_pop/o_rdata read side; o_level occupancy 0..DEPTH; o_full/o_empty status.
module exp_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8   // must be at least 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Explicit wrap so non-power-of-two depths still cycle through DEPTH slots.
  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    f_next = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when a slot frees up in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rptr];
  assign o_level   = r_level;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= f_next(r_wptr);
      if (w_do_pop)  r_rptr <= f_next(r_rptr);
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbfp_denorm.sv
// Purpose : restores full-scale lanes from a CBFP block using queued per-block exponents.
// Latency : 1 cycle from valid_in to valid_out/dout.
// Backpr. : none; exponent overflow drops the push (ovf_err), a block with no exponent uses 0 (unf_err).
// Ports   : clk/rstn; exp_valid/exp_add/exp_sub push an exponent pair; valid_in + din_* present a block;
//           dout_*/valid_out registered result; fifo_level occupancy; ovf_err/unf_err sticky until reset.
module cbfp_denorm #(
  parameter int DATA_WIDTH = cbfp_denorm_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH  = cbfp_denorm_pkg::OUT_WIDTH,
  parameter int BLOCK_SIZE = cbfp_denorm_pkg::BLOCK_SIZE,
  parameter int LZC_WIDTH  = cbfp_denorm_pkg::LZC_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int HEADROOM   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          exp_valid,
  input  logic [LZC_WIDTH-1:0]          exp_add,
  input  logic [LZC_WIDTH-1:0]          exp_sub,
  input  logic                          valid_in,
  input  logic signed [DATA_WIDTH-1:0]  din_R_add  [BLOCK_SIZE],
  input  logic signed [DATA_WIDTH-1:0]  din_Q_add  [BLOCK_SIZE],
  input  logic signed [DATA_WIDTH-1:0]  din_R_sub  [BLOCK_SIZE],
  input  logic signed [DATA_WIDTH-1:0]  din_Q_sub  [BLOCK_SIZE],
  output logic signed [OUT_WIDTH-1:0]   dout_R_add [BLOCK_SIZE],
  output logic signed [OUT_WIDTH-1:0]   dout_Q_add [BLOCK_SIZE],
  output logic signed [OUT_WIDTH-1:0]   dout_R_sub [BLOCK_SIZE],
  output logic signed [OUT_WIDTH-1:0]   dout_Q_sub [BLOCK_SIZE],
  output logic                          valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_err,
  output logic                          unf_err
);

  import cbfp_denorm_pkg::exp_pair_t;

  exp_pair_t w_in_pair;
  exp_pair_t w_head;
  exp_pair_t w_sel;
  logic      w_full;
  logic      w_empty;
  logic      w_bypass;
  logic      w_push;
  logic      w_pop;

  logic signed [OUT_WIDTH-1:0] w_ra [BLOCK_SIZE];
  logic signed [OUT_WIDTH-1:0] w_qa [BLOCK_SIZE];
  logic signed [OUT_WIDTH-1:0] w_rs [BLOCK_SIZE];
  logic signed [OUT_WIDTH-1:0] w_qs [BLOCK_SIZE];

  // Sign-extend, apply headroom, then truncating arithmetic shift. Exponents
  // past the output width leave only the sign fill (0 or -1).
  function automatic logic signed [OUT_WIDTH-1:0] f_denorm(
    input logic signed [DATA_WIDTH-1:0] d,
    input logic [LZC_WIDTH-1:0]         e
  );
    logic signed [OUT_WIDTH-1:0] v;
    v = signed'(OUT_WIDTH'(d)) <<< HEADROOM;
    if (int'(e) >= OUT_WIDTH) begin
      f_denorm = {OUT_WIDTH{d[DATA_WIDTH-1]}};
    end else begin
      f_denorm = v >>> e;
    end
  endfunction

  assign w_in_pair = '{exp_add: exp_add, exp_sub: exp_sub};

  // An empty FIFO with a simultaneous push and block forwards the new pair
  // straight through instead of round-tripping it through storage.
  assign w_bypass = exp_valid & valid_in & w_empty;
  assign w_push   = exp_valid & ~w_bypass;
  assign w_pop    = valid_in & ~w_empty;

  exp_fifo #(
    .WIDTH ($bits(exp_pair_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_exp_fifo (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_push  (w_push),
    .i_wdata (w_in_pair),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_sel = w_head;
    if (w_bypass) begin
      w_sel = w_in_pair;
    end else if (w_empty) begin
      w_sel = '0;
    end
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
    assign w_ra[g] = f_denorm(din_R_add[g], w_sel.exp_add);
    assign w_qa[g] = f_denorm(din_Q_add[g], w_sel.exp_add);
    assign w_rs[g] = f_denorm(din_R_sub[g], w_sel.exp_sub);
    assign w_qs[g] = f_denorm(din_Q_sub[g], w_sel.exp_sub);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        dout_R_add[i] <= '0;
        dout_Q_add[i] <= '0;
        dout_R_sub[i] <= '0;
        dout_Q_sub[i] <= '0;
      end
    end else begin
      valid_out <= valid_in;
      // A full FIFO only frees a slot when this cycle also pops.
      if (exp_valid && w_full && !w_pop) ovf_err <= 1'b1;
      if (valid_in && w_empty && !exp_valid) unf_err <= 1'b1;
      if (valid_in) begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          dout_R_add[i] <= w_ra[i];
          dout_Q_add[i] <= w_qa[i];
          dout_R_sub[i] <= w_rs[i];
          dout_Q_sub[i] <= w_qs[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbfp_denorm.sv
module tb_cbfp_denorm;

  localparam int DW = 12;
  localparam int OW = 16;
  localparam int BS = 8;
  localparam int LW = 5;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rstn;
  logic exp_valid;
  logic [LW-1:0] exp_add;
  logic [LW-1:0] exp_sub;
  logic valid_in;
  logic signed [DW-1:0] din_R_add [BS];
  logic signed [DW-1:0] din_Q_add [BS];
  logic signed [DW-1:0] din_R_sub [BS];
  logic signed [DW-1:0] din_Q_sub [BS];
  logic signed [OW-1:0] dout_R_add [BS];
  logic signed [OW-1:0] dout_Q_add [BS];
  logic signed [OW-1:0] dout_R_sub [BS];
  logic signed [OW-1:0] dout_Q_sub [BS];
  logic valid_out;
  logic [$clog2(FD):0] fifo_level;
  logic ovf_err;
  logic unf_err;

  always #5 clk = ~clk;

  cbfp_denorm #(
    .DATA_WIDTH (DW),
    .OUT_WIDTH  (OW),
    .BLOCK_SIZE (BS),
    .LZC_WIDTH  (LW),
    .FIFO_DEPTH (FD),
    .HEADROOM   (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .exp_valid  (exp_valid),
    .exp_add    (exp_add),
    .exp_sub    (exp_sub),
    .valid_in   (valid_in),
    .din_R_add  (din_R_add),
    .din_Q_add  (din_Q_add),
    .din_R_sub  (din_R_sub),
    .din_Q_sub  (din_Q_sub),
    .dout_R_add (dout_R_add),
    .dout_Q_add (dout_Q_add),
    .dout_R_sub (dout_R_sub),
    .dout_Q_sub (dout_Q_sub),
    .valid_out  (valid_out),
    .fifo_level (fifo_level),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  typedef struct {
    int cyc;
    int ra;
    int qa;
    int rs;
    int qs;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every valid_out must match the oldest expected block and arrive
  // in the cycle the stimulus predicted.
  always @(negedge clk) begin : mon
    exp_t e;
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_cycle", cyc, e.cyc);
        for (int i = 0; i < BS; i++) begin
          check($sformatf("dout_R_add[%0d]", i), int'(dout_R_add[i]), e.ra);
          check($sformatf("dout_Q_add[%0d]", i), int'(dout_Q_add[i]), e.qa);
          check($sformatf("dout_R_sub[%0d]", i), int'(dout_R_sub[i]), e.rs);
          check($sformatf("dout_Q_sub[%0d]", i), int'(dout_Q_sub[i]), e.qs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    valid_in  = 1'b0;
  endtask

  task automatic push(input int a, input int s);
    exp_valid = 1'b1;
    exp_add   = LW'(a);
    exp_sub   = LW'(s);
  endtask

  task automatic blk(input int ra, input int qa, input int rs, input int qs,
                     input bit expect_out,
                     input int era, input int eqa, input int ers, input int eqs);
    for (int i = 0; i < BS; i++) begin
      din_R_add[i] = DW'(ra);
      din_Q_add[i] = DW'(qa);
      din_R_sub[i] = DW'(rs);
      din_Q_sub[i] = DW'(qs);
    end
    valid_in = 1'b1;
    if (expect_out) sb.push_back('{cyc + 1, era, eqa, ers, eqs});
  endtask

  // Pops after filling with pairs (i, i+8), i = 1..9, lanes 1024 / -1024.
  int t_ra [9] = '{8192, 4096, 2048, 1024, 512, 256, 128, 64, 32};
  int t_rs [9] = '{32, 16, 8, 4, 2, 1, 0, 0, 0};
  int t_qs [9] = '{-32, -16, -8, -4, -2, -1, -1, -1, -1};

  initial begin
    rstn      = 1'b0;
    exp_valid = 1'b0;
    exp_add   = '0;
    exp_sub   = '0;
    valid_in  = 1'b0;
    blk(0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ovf", int'(ovf_err), 0);
    check("rst_unf", int'(unf_err), 0);
    check("rst_dout_R_add0", int'(dout_R_add[0]), 0);
    rstn = 1'b1;
    tick();

    // Queued pair {3,5} used two cycles later.
    push(3, 5);
    tick();
    check("level_after_push", int'(fifo_level), 1);
    tick();
    blk(100, 50, -100, 50, 1'b1, 200, 100, -50, 25);
    tick();
    check("level_after_pop", int'(fifo_level), 0);
    check("unf_after_normal", int'(unf_err), 0);

    // Bypass on an empty FIFO.
    push(0, 0);
    blk(2047, 2047, 2047, 2047, 1'b1, 32752, 32752, 32752, 32752);
    tick();
    check("bypass_level", int'(fifo_level), 0);
    check("bypass_unf", int'(unf_err), 0);

    // Underflow: exponent 0, error sticky.
    blk(-2048, -2048, -2048, -2048, 1'b1, -32768, -32768, -32768, -32768);
    tick();
    check("unf_set", int'(unf_err), 1);
    push(1, 1);
    tick();
    blk(16, 16, 16, 16, 1'b1, 128, 128, 128, 128);
    tick();
    check("unf_sticky", int'(unf_err), 1);
    check("level_idle", int'(fifo_level), 0);

    // Fill, overflow drop, then push+pop while full, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      push(i, i + 8);
      tick();
    end
    check("full_level", int'(fifo_level), 8);
    check("ovf_before_drop", int'(ovf_err), 0);
    push(30, 30);
    tick();
    check("drop_level", int'(fifo_level), 8);
    check("ovf_set", int'(ovf_err), 1);
    for (int i = 1; i <= 9; i++) begin
      if (i == 1) push(9, 17);
      blk(1024, -1024, 1024, -1024, 1'b1, t_ra[i-1], -t_ra[i-1], t_rs[i-1], t_qs[i-1]);
      tick();
      if (i == 1) check("full_pushpop_level", int'(fifo_level), 8);
    end
    check("drained_level", int'(fifo_level), 0);

    // Large exponent leaves only the sign fill.
    push(20, 20);
    blk(-1, 5, -1, 5, 1'b1, -1, 0, -1, 0);
    tick();

    // Reset with level 4 and a block in flight.
    for (int i = 0; i < 5; i++) begin
      push(2, 2);
      tick();
    end
    blk(100, 100, 100, 100, 1'b0, 0, 0, 0, 0);
    tick();
    check("pre_rst_level", int'(fifo_level), 4);
    check("pre_rst_valid", int'(valid_out), 1);
    check("pre_rst_ovf", int'(ovf_err), 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid_out", int'(valid_out), 0);
    check("mid_rst_level", int'(fifo_level), 0);
    check("mid_rst_dout_R_add0", int'(dout_R_add[0]), 0);
    check("mid_rst_dout_Q_sub7", int'(dout_Q_sub[BS-1]), 0);
    check("mid_rst_ovf", int'(ovf_err), 0);
    check("mid_rst_unf", int'(unf_err), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    blk(100, 100, 100, 100, 1'b1, 1600, 1600, 1600, 1600);
    tick();
    check("post_rst_unf", int'(unf_err), 1);
    check("post_rst_level", int'(fifo_level), 0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cbfp_denorm.md
CBFP_DENORM -- requirements
Module: cbfp_denorm

Interface
REQ-001 SHALL expose parameters: DATA_WIDTH 12 (normalised input width); OUT_WIDTH 16 (denormalised output width); BLOCK_SIZE 8 (lanes per block); LZC_WIDTH 5 (exponent width); FIFO_DEPTH 8 (exponent-pair entries); HEADROOM 4 (left pre-shift before denormalisation).
REQ-002 SHALL have ports: clk input 1, the single clock; rstn input 1, asynchronous active-low reset (fixed by decision).
REQ-003 SHALL have ports: exp_valid input 1, push strobe; exp_add input LZC_WIDTH, add-path block exponent; exp_sub input LZC_WIDTH, sub-path block exponent.
REQ-004 SHALL have ports: valid_in input 1, normalised block present; din_R_add, din_Q_add, din_R_sub, din_Q_sub input signed DATA_WIDTH x BLOCK_SIZE, normalised lanes.
REQ-005 SHALL have ports: dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub output signed OUT_WIDTH x BLOCK_SIZE; valid_out output 1; fifo_level output clog2(FIFO_DEPTH)+1; ovf_err output 1, sticky; unf_err output 1, sticky.

Function
REQ-006 SHALL store each exponent pair {exp_add, exp_sub} in an in-order FIFO when exp_valid=1, with one push per cycle maximum.
REQ-007 SHALL pop one pair in every cycle with valid_in=1 and apply it to that block.
REQ-008 SHALL compute each add-path lane as (sign_extend(din) <<< HEADROOM) >>> exp_add, with a truncating arithmetic right shift and the result at OUT_WIDTH.
REQ-009 SHALL compute each sub-path lane the same way using exp_sub.
REQ-010 SHALL produce 0 for non-negative lanes and -1 for negative lanes when the exponent is at least OUT_WIDTH.
REQ-011 SHALL register outputs so that valid_out and data appear exactly 1 cycle after valid_in.
REQ-012 SHALL hold outputs between blocks and SHALL drive valid_out=0 in every cycle not preceded by valid_in.
REQ-013 SHALL perform both push and pop when exp_valid and valid_in are high together and the FIFO is non-empty; the level is unchanged and the popped pair is the oldest entry.
REQ-014 SHALL bypass the FIFO when it is empty and exp_valid and valid_in are high together: the incoming pair is used directly, no underflow is flagged, and the level stays 0.
REQ-015 SHALL, when the FIFO is empty and valid_in=1 with no bypass, use exponent 0 for both paths, set unf_err, and still assert valid_out.
REQ-016 SHALL, when the FIFO is full and exp_valid=1 with no pop, drop the push, set ovf_err, and leave the contents unchanged.
REQ-017 SHALL, when the FIFO is full and push and pop occur together, accept both with no error.
REQ-018 SHALL implement read and write pointers that wrap modulo FIFO_DEPTH, with fifo_level tracking occupancy from 0 to FIFO_DEPTH.

Reset
REQ-019 SHALL, on rstn low, asynchronously clear both pointers, fifo_level, valid_out, ovf_err, unf_err and all dout lanes to 0.
REQ-020 SHALL discard stored exponents on reset asserted mid-block, with the first cycle after release behaving as an empty FIFO.
REQ-021 SHALL clear ovf_err and unf_err only by reset.

Structure
REQ-022 SHALL place DATA_WIDTH, OUT_WIDTH, LZC_WIDTH, BLOCK_SIZE and the exponent-pair struct typedef in the shared CBFP package.
REQ-023 SHALL instantiate a single sub-module, exp_fifo (synchronous FIFO with level, full and empty), and SHALL perform lane shifting in the top level using generate loops.

Verification
REQ-024 SHALL cover: push {3,5}, then 2 cycles later valid_in with din_R_add[0]=100 and din_R_sub[0]=-100 -> next cycle valid_out=1, dout_R_add[0]=200, dout_R_sub[0]=-50, level 1->0.
REQ-025 SHALL cover: empty FIFO with exp_valid={0,0} and valid_in in the same cycle, din=2047 -> dout=32752, unf_err=0, level stays 0.
REQ-026 SHALL cover: valid_in with the FIFO empty and din=-2048 -> dout=-32768, unf_err=1 sticky across later valid blocks.
REQ-027 SHALL cover: 9 pushes with no pops -> level=8, ovf_err=1, the 9th pair dropped; 8 subsequent pops return pairs 1..8 in order.
REQ-028 SHALL cover: exponent 20 with din=-1 -> dout=-1; exponent 20 with din=5 -> dout=0.
REQ-029 SHALL cover: rstn pulsed low for 1 cycle with level=4 and a block in flight -> all outputs 0 immediately, level=0, and the next valid_in flags underflow.
